// File: rtl/sync_fifo_flags_if.sv
// ---------------------------------------------------------------------------
// sync_fifo_flags_if
//   Handshake/data bundle for sync_fifo_flags. Clock and reset are not part
//   of the bundle; they stay plain ports on the FIFO.
//
//   Signals:
//     clear        : synchronous flush request
//     wr_en / din  : write request and write data
//     rd_en / dout : read request and read data
//     full, almost_full, empty, almost_empty : occupancy flags
//     count        : occupancy, 0..FIFO_DEPTH
//     overflow, underflow : sticky error flags
//
//   Modports:
//     master : the user of the FIFO (producer and consumer side)
//     slave  : the FIFO itself
// ---------------------------------------------------------------------------
interface sync_fifo_flags_if #(
  parameter int FIFO_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH      = 16
);
  logic                         clear;
  logic                         wr_en;
  logic [FIFO_DATA_WIDTH-1:0]   din;
  logic                         full;
  logic                         almost_full;
  logic                         rd_en;
  logic [FIFO_DATA_WIDTH-1:0]   dout;
  logic                         empty;
  logic                         almost_empty;
  logic [$clog2(FIFO_DEPTH):0]  count;
  logic                         overflow;
  logic                         underflow;

  modport master (
    output clear, wr_en, din, rd_en,
    input  full, almost_full, dout, empty, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  clear, wr_en, din, rd_en,
    output full, almost_full, dout, empty, almost_empty, count,
           overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// ---------------------------------------------------------------------------
// sync_fifo_flags
//   Single-clock FIFO with occupancy count, programmable almost-full /
//   almost-empty flags, sticky overflow/underflow flags and synchronous
//   flush (clear).
//
//   Ports:
//     clock : rising-edge clock for all state
//     reset : asynchronous active-high reset (contents discarded at once)
//     bus   : sync_fifo_flags_if.slave (clear, wr_en/din, rd_en/dout,
//             full, almost_full, empty, almost_empty, count,
//             overflow, underflow)
//
//   Build option:
//     SYNC_FIFO_FWFT_EN : when defined, first-word-fall-through mode; dout
//                         shows mem[rd_ptr] whenever the FIFO is not empty
//                         and is 0 when empty. When undefined, dout is a
//                         register loaded on the edge that accepts a read.
//
//   Parameters: FIFO_DEPTH must be a power of 2 and >= 4;
//   ALMOST_FULL_THRESH in 1..FIFO_DEPTH; ALMOST_EMPTY_THRESH in
//   0..FIFO_DEPTH-1.
// ---------------------------------------------------------------------------
module sync_fifo_flags #(
  parameter int FIFO_DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH          = 16,
  parameter int ALMOST_FULL_THRESH  = 14,
  parameter int ALMOST_EMPTY_THRESH = 2
) (
  input  logic              clock,
  input  logic              reset,
  sync_fifo_flags_if.slave  bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(ALMOST_FULL_THRESH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(ALMOST_EMPTY_THRESH);

  // Storage is never reset so it can map onto block RAM.
  logic [FIFO_DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [PTR_W-1:0]           wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]           rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]           count_reg, count_next;
  logic                       overflow_reg, underflow_reg;
  logic                       full_w, empty_w;
  logic                       wr_accept, rd_accept;
  logic [FIFO_DATA_WIDTH-1:0] rd_word;
  logic [FIFO_DATA_WIDTH-1:0] dout_raw;
  logic [FIFO_DATA_WIDTH-1:0] dout_clean;

  // Flags come only from the registered count, never from wr_en/rd_en.
  assign full_w  = (count_reg == DEPTH_C);
  assign empty_w = (count_reg == '0);

  // clear wins over both requests: nothing is stored or popped that cycle.
  assign wr_accept = bus.wr_en && !full_w  && !bus.clear;
  assign rd_accept = bus.rd_en && !empty_w && !bus.clear;

  assign rd_word = mem[rd_ptr_reg];

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (bus.clear) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      // Depth is a power of 2, so plain binary increment wraps correctly.
      if (wr_accept) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (rd_accept) rd_ptr_next = rd_ptr_reg + 1'b1;
      case ({wr_accept, rd_accept})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      if (bus.clear) begin
        overflow_reg  <= 1'b0;
        underflow_reg <= 1'b0;
      end else begin
        // Errors are judged on the request, independent of the other port.
        if (bus.wr_en && full_w)  overflow_reg  <= 1'b1;
        if (bus.rd_en && empty_w) underflow_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (wr_accept) mem[wr_ptr_reg] <= bus.din;
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Show-ahead: head word is visible as soon as count is non-zero.
  assign dout_raw = empty_w ? '0 : rd_word;
`else
  logic [FIFO_DATA_WIDTH-1:0] dout_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dout_reg <= '0;
    end else if (bus.clear) begin
      dout_reg <= '0;
    end else if (rd_accept) begin
      dout_reg <= rd_word;
    end
  end

  assign dout_raw = dout_reg;
`endif

  // Any bit that is not a clean 1 (0, X or Z) leaves the block as 0.
  generate
    for (genvar gi = 0; gi < FIFO_DATA_WIDTH; gi++) begin : g_dout_scrub
      assign dout_clean[gi] = (dout_raw[gi] === 1'b1);
    end
  endgenerate

  assign bus.dout         = dout_clean;
  assign bus.count        = count_reg;
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (count_reg >= AF_C);
  assign bus.almost_empty = (count_reg <= AE_C);
  assign bus.overflow     = overflow_reg;
  assign bus.underflow    = underflow_reg;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_flags
//   Self-checking bench for sync_fifo_flags. A queue-based model tracks the
//   stored words and sticky flags; a negedge process compares every DUT
//   output with it each cycle, and directed sections add literal checks.
// ---------------------------------------------------------------------------
module tb_sync_fifo_flags;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic clock = 1'b0;
  logic reset;

  sync_fifo_flags_if #(.FIFO_DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus();

  sync_fifo_flags #(
    .FIFO_DATA_WIDTH    (DW),
    .FIFO_DEPTH         (DEPTH),
    .ALMOST_FULL_THRESH (AF),
    .ALMOST_EMPTY_THRESH(AE)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Reference model: stored words, sticky flags, registered-read output.
  logic [DW-1:0] q[$];
  logic          m_ovf;
  logic          m_unf;
  logic [DW-1:0] m_dout;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_dout = '0;
  endfunction

  function automatic void model_step(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
    bit            was_full;
    bit            was_empty;
    logic [DW-1:0] v;
    if (c) begin
      model_reset();
      return;
    end
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (w && was_full)  m_ovf = 1'b1;
    if (r && was_empty) m_unf = 1'b1;
    if (r && !was_empty) begin
      v = q.pop_front();
      m_dout = v;
    end
    if (w && !was_full) q.push_back(d);
  endfunction

  function automatic logic [DW-1:0] exp_dout();
`ifdef SYNC_FIFO_FWFT_EN
    return (q.size() != 0) ? q[0] : '0;
`else
    return m_dout;
`endif
  endfunction

  always @(negedge clock) begin
    if (chk_en) begin
      check("count",        64'(bus.count),    64'(q.size()));
      check("empty",        64'(bus.empty),    64'(q.size() == 0));
      check("full",         64'(bus.full),     64'(q.size() == DEPTH));
      check("almost_full",  64'(bus.almost_full),  64'(q.size() >= AF));
      check("almost_empty", 64'(bus.almost_empty), 64'(q.size() <= AE));
      check("overflow",     64'(bus.overflow),  64'(m_ovf));
      check("underflow",    64'(bus.underflow), 64'(m_unf));
      check("dout",         64'(bus.dout),      64'(exp_dout()));
    end
  end

  // One clock: drive inputs between edges, advance the model at the edge.
  task automatic cycle(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
    bus.wr_en = w;
    bus.din   = d;
    bus.rd_en = r;
    bus.clear = c;
    @(posedge clock);
    model_step(w, d, r, c);
    #2;
    $display("[TB] t=%0t wr=%0b din=%08h rd=%0b clr=%0b -> count=%0d dout=%08h ovf=%0b unf=%0b",
             $time, w, d, r, c, bus.count, bus.dout, bus.overflow, bus.underflow);
  endtask

  initial begin
    logic [DW-1:0] exp_w;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.clear = 1'b0;
    bus.din   = '0;
    reset = 1'b1;
    model_reset();
    #12;
    check("rst_count",  64'(bus.count), 64'd0);
    check("rst_empty",  64'(bus.empty), 64'd1);
    check("rst_ae",     64'(bus.almost_empty), 64'd1);
    check("rst_full",   64'(bus.full), 64'd0);
    check("rst_af",     64'(bus.almost_full), 64'd0);
    check("rst_ovf",    64'(bus.overflow), 64'd0);
    check("rst_unf",    64'(bus.underflow), 64'd0);
    check("rst_dout",   64'(bus.dout), 64'd0);
    #1 reset = 1'b0;
    chk_en = 1'b1;

    // Fill 1..16.
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b1, DW'(i), 1'b0, 1'b0);
      check("fill_count", 64'(bus.count), 64'(i));
      check("fill_af",    64'(bus.almost_full), 64'(i >= 14));
    end
    check("fill_full", 64'(bus.full), 64'd1);

    // Overflow attempt.
    cycle(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    check("ovf_set",   64'(bus.overflow), 64'd1);
    check("ovf_count", 64'(bus.count), 64'd16);

    // Drain in order.
    for (int i = 0; i < 16; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      check("drain_dout", 64'(bus.dout), 64'(i + 1));
`endif
      cycle(1'b0, '0, 1'b1, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
      check("drain_dout", 64'(bus.dout), 64'(i + 1));
`endif
      check("drain_ovf_sticky", 64'(bus.overflow), 64'd1);
    end
    check("drain_empty", 64'(bus.empty), 64'd1);
    check("drain_count", 64'(bus.count), 64'd0);

    // Simultaneous read+write on empty.
    cycle(1'b1, 32'hA5A5A5A5, 1'b1, 1'b0);
    check("unf_set",   64'(bus.underflow), 64'd1);
    check("unf_count", 64'(bus.count), 64'd1);
`ifdef SYNC_FIFO_FWFT_EN
    check("unf_dout", 64'(bus.dout), 64'hA5A5A5A5);
    cycle(1'b0, '0, 1'b1, 1'b0);
`else
    check("unf_dout_hold", 64'(bus.dout), 64'h10);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("unf_read", 64'(bus.dout), 64'hA5A5A5A5);
`endif
    check("unf_empty", 64'(bus.empty), 64'd1);

    // Clear with a concurrent write, count=5, overflow still set.
    for (int i = 0; i < 5; i++) cycle(1'b1, DW'(32'h100 + i), 1'b0, 1'b0);
    check("pre_clr_count", 64'(bus.count), 64'd5);
    check("pre_clr_ovf",   64'(bus.overflow), 64'd1);
    cycle(1'b1, 32'hBAD0BAD0, 1'b0, 1'b1);
    check("clr_count", 64'(bus.count), 64'd0);
    check("clr_empty", 64'(bus.empty), 64'd1);
    check("clr_ovf",   64'(bus.overflow), 64'd0);
    check("clr_unf",   64'(bus.underflow), 64'd0);
    check("clr_dout",  64'(bus.dout), 64'd0);
    cycle(1'b1, 32'h77, 1'b0, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
    check("post_clr_word", 64'(bus.dout), 64'h77);
    cycle(1'b0, '0, 1'b1, 1'b0);
`else
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("post_clr_word", 64'(bus.dout), 64'h77);
`endif

    // Wrap-around: preload 8, then 40 simultaneous read/write cycles.
    for (int k = 0; k < 8; k++) cycle(1'b1, DW'(32'h1000 + k), 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      exp_w = (k < 8) ? DW'(32'h1000 + k) : DW'(32'h2000 + k - 8);
`ifdef SYNC_FIFO_FWFT_EN
      check("wrap_dout", 64'(bus.dout), 64'(exp_w));
`endif
      cycle(1'b1, DW'(32'h2000 + k), 1'b1, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
      check("wrap_dout", 64'(bus.dout), 64'(exp_w));
`endif
      check("wrap_count", 64'(bus.count), 64'd8);
    end

    // Randomised traffic: write-heavy then read-heavy, occasional clear.
    for (int n = 0; n < 400; n++) begin
      int pw;
      pw = (n < 200) ? 70 : 30;
      cycle($urandom_range(0, 99) < pw, $urandom(), $urandom_range(0, 99) < (100 - pw),
            $urandom_range(0, 99) < 2);
    end

    // Asynchronous reset in the middle of a write burst.
    for (int i = 0; i < 6; i++) cycle(1'b1, DW'(32'h300 + i), 1'b0, 1'b0);
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    check("areset_count", 64'(bus.count), 64'd0);
    check("areset_empty", 64'(bus.empty), 64'd1);
    check("areset_ae",    64'(bus.almost_empty), 64'd1);
    check("areset_full",  64'(bus.full), 64'd0);
    check("areset_ovf",   64'(bus.overflow), 64'd0);
    check("areset_dout",  64'(bus.dout), 64'd0);
    #4;
    reset = 1'b0;
    bus.wr_en = 1'b0;
    cycle(1'b1, 32'hCAFE0001, 1'b0, 1'b0);
    check("post_rst_count", 64'(bus.count), 64'd1);
    cycle(1'b0, '0, 1'b1, 1'b0);

`ifdef SYNC_FIFO_FWFT_EN
    // Show-ahead: word visible the cycle after the write, no rd_en.
    cycle(1'b1, 32'h12345678, 1'b0, 1'b0);
    check("fwft_dout",  64'(bus.dout), 64'h12345678);
    check("fwft_empty", 64'(bus.empty), 64'd0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("fwft_pop_empty", 64'(bus.empty), 64'd1);
    check("fwft_pop_dout",  64'(bus.dout), 64'd0);
`endif

    cycle(1'b0, '0, 1'b0, 1'b0);
    @(negedge clock);
    #1;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
